// File: rtl/control_pipe_if.sv
// ID/EX control-pipe bus: IF/ID-side inputs and EX-side control bundle.
// master drives the instruction side, slave is the control pipe.
interface control_pipe_if #(
  parameter int OPCODE_W = 5,
  parameter int DEPTH_W  = 4
);
  logic                in_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                hazard;
  logic                hold;
  logic                flush;

  logic                ex_valid;
  logic                ex_branch;
  logic                ex_regwrite;
  logic                ex_memtoreg;
  logic                ex_memread;
  logic                ex_memwrite;
  logic                ex_alusrc;
  logic                ex_aluop;
  logic                ex_regdist;
  logic                ex_branchtype;
  logic                ex_push;
  logic                ex_pop;
  logic                ex_ret;
  logic                ex_jump;
  logic                stall_req;
  logic [DEPTH_W-1:0]  depth;
  logic                stack_ovf;
  logic                stack_unf;

  modport master (
    output in_valid, opcode, hazard, hold, flush,
    input  ex_valid, ex_branch, ex_regwrite,
    input  ex_memtoreg, ex_memread, ex_memwrite,
    input  ex_alusrc, ex_aluop, ex_regdist,
    input  ex_branchtype, ex_push, ex_pop,
    input  ex_ret, ex_jump, stall_req,
    input  depth, stack_ovf, stack_unf
  );

  modport slave (
    input  in_valid, opcode, hazard, hold, flush,
    output ex_valid, ex_branch, ex_regwrite,
    output ex_memtoreg, ex_memread, ex_memwrite,
    output ex_alusrc, ex_aluop, ex_regdist,
    output ex_branchtype, ex_push, ex_pop,
    output ex_ret, ex_jump, stall_req,
    output depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/control_pipe.sv
// ID-stage control decode registered into ID/EX, with CALL/RET depth
// tracking and a RET bubble FSM that stalls fetch.
module control_pipe #(
  parameter int OPCODE_W    = 5,
  parameter int STACK_DEPTH = 8,
  parameter int RET_BUBBLES = 2,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH+1)
) (
  input logic           clk,
  input logic           rst,
  control_pipe_if.slave bus
);

  localparam logic [OPCODE_W-1:0] OP_ART  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LOG  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BQE  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_CALL = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_RET  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_CRY  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_IMM  = OPCODE_W'(10);

  localparam int WC_W =
    (RET_BUBBLES > 1) ? $clog2(RET_BUBBLES+1) : 1;
  localparam bit HAS_WAIT = (RET_BUBBLES > 0);
  localparam logic [DEPTH_W-1:0] DMAX =
    DEPTH_W'(STACK_DEPTH);

  typedef struct packed {
    logic branch;
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic alusrc;
    logic aluop;
    logic regdist;
    logic branchtype;
    logic push;
    logic pop;
    logic ret;
    logic jump;
  } ctrl_t;

  typedef enum logic {
    IDLE,
    RET_WAIT
  } state_t;

  ctrl_t             dec;
  ctrl_t             ex_q, ex_d;
  logic              valid_q, valid_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  state_t            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;

  logic accept;
  logic at_max;
  logic at_zero;
  logic call_sup;
  logic ret_sup;
  logic take;

  always_comb begin
    dec = '0;
    unique case (bus.opcode)
      OP_ART, OP_LOG: begin
        dec.regdist  = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_JMP: dec.jump = 1'b1;
      OP_BQE: dec.branch = 1'b1;
      OP_BNE: begin
        dec.branch     = 1'b1;
        dec.branchtype = 1'b1;
      end
      OP_CALL: begin
        dec.push = 1'b1;
        dec.jump = 1'b1;
      end
      OP_RET: begin
        dec.pop = 1'b1;
        dec.ret = 1'b1;
      end
      OP_LD: begin
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_ST: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_CRY: dec.regwrite = 1'b1;
      OP_IMM: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  assign accept = bus.in_valid & ~bus.hazard &
                  ~bus.hold & ~bus.flush &
                  (state_q == IDLE);
  assign at_max   = (depth_q == DMAX);
  assign at_zero  = (depth_q == '0);
  assign call_sup = dec.push & at_max;
  assign ret_sup  = dec.pop & at_zero;
  assign take     = accept & ~call_sup & ~ret_sup;

  // flush outranks hold; a suppressed CALL/RET becomes a bubble
  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    if (bus.flush) begin
      ex_d    = '0;
      valid_d = 1'b0;
    end else if (!bus.hold) begin
      ex_d    = take ? dec : '0;
      valid_d = take;
    end
  end

  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q | (accept & call_sup);
    unf_d   = unf_q | (accept & ret_sup);
    if (take && dec.push)
      depth_d = depth_q + 1'b1;
    else if (take && dec.pop)
      depth_d = depth_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (HAS_WAIT && take && dec.pop) begin
          state_d = RET_WAIT;
          wcnt_d  = WC_W'(RET_BUBBLES);
        end
      end
      RET_WAIT: begin
        wcnt_d = wcnt_q - 1'b1;
        if (bus.flush || wcnt_q == WC_W'(1)) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_regwrite   = ex_q.regwrite;
  assign bus.ex_memtoreg   = ex_q.memtoreg;
  assign bus.ex_memread    = ex_q.memread;
  assign bus.ex_memwrite   = ex_q.memwrite;
  assign bus.ex_alusrc     = ex_q.alusrc;
  assign bus.ex_aluop      = ex_q.aluop;
  assign bus.ex_regdist    = ex_q.regdist;
  assign bus.ex_branchtype = ex_q.branchtype;
  assign bus.ex_push       = ex_q.push;
  assign bus.ex_pop        = ex_q.pop;
  assign bus.ex_ret        = ex_q.ret;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.stall_req     = (state_q == RET_WAIT);
  assign bus.depth         = depth_q;
  assign bus.stack_ovf     = ovf_q;
  assign bus.stack_unf     = unf_q;

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe with STACK_DEPTH=2, RET_BUBBLES=2.
// Stimulus queues expected post-edge state; a monitor pops and compares.
module tb_control_pipe;

  localparam int OW = 5;
  localparam int DW = 2;

  localparam logic [4:0] ART  = 5'd0;
  localparam logic [4:0] LOG  = 5'd1;
  localparam logic [4:0] JMP  = 5'd2;
  localparam logic [4:0] BQE  = 5'd3;
  localparam logic [4:0] BNE  = 5'd4;
  localparam logic [4:0] CALL = 5'd5;
  localparam logic [4:0] RET  = 5'd6;
  localparam logic [4:0] LD   = 5'd7;
  localparam logic [4:0] ST   = 5'd8;
  localparam logic [4:0] CRY  = 5'd9;
  localparam logic [4:0] IMM  = 5'd10;
  localparam logic [4:0] UND  = 5'd31;

  // {branch,regwrite,memtoreg,memread,memwrite,alusrc,
  //  aluop,regdist,branchtype,push,pop,ret,jump}
  localparam logic [12:0] B0    = 13'b0000000000000;
  localparam logic [12:0] B_ART = 13'b0100000100000;
  localparam logic [12:0] B_JMP = 13'b0000000000001;
  localparam logic [12:0] B_BQE = 13'b1000000000000;
  localparam logic [12:0] B_BNE = 13'b1000000010000;
  localparam logic [12:0] B_CAL = 13'b0000000001001;
  localparam logic [12:0] B_RET = 13'b0000000000110;
  localparam logic [12:0] B_LD  = 13'b0111010000000;
  localparam logic [12:0] B_ST  = 13'b0000110000000;
  localparam logic [12:0] B_CRY = 13'b0100000000000;
  localparam logic [12:0] B_IMM = 13'b0100010000000;

  typedef struct {
    string       name;
    logic        v;
    logic [12:0] b;
    logic        st;
    logic [1:0]  d;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  control_pipe_if #(.OPCODE_W(OW), .DEPTH_W(DW)) bus ();

  control_pipe #(
    .OPCODE_W   (OW),
    .STACK_DEPTH(2),
    .RET_BUBBLES(2),
    .DEPTH_W    (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(
    input string      nm,
    input logic       r,
    input logic       iv,
    input logic [4:0] op,
    input logic       hz,
    input logic       hd,
    input logic       fl,
    input logic       ev,
    input logic [12:0] eb,
    input logic       est,
    input logic [1:0] ed,
    input logic       eo,
    input logic       eu
  );
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.in_valid = iv;
    bus.opcode   = op;
    bus.hazard   = hz;
    bus.hold     = hd;
    bus.flush    = fl;
    e.name = nm;
    e.v    = ev;
    e.b    = eb;
    e.st   = est;
    e.d    = ed;
    e.ovf  = eo;
    e.unf  = eu;
    q.push_back(e);
  endtask

  always begin
    exp_t        e;
    logic [12:0] ab;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e  = q.pop_front();
      ab = {bus.ex_branch, bus.ex_regwrite,
            bus.ex_memtoreg, bus.ex_memread,
            bus.ex_memwrite, bus.ex_alusrc,
            bus.ex_aluop, bus.ex_regdist,
            bus.ex_branchtype, bus.ex_push,
            bus.ex_pop, bus.ex_ret, bus.ex_jump};
      checks++;
      if (bus.ex_valid !== e.v || ab !== e.b ||
          bus.stall_req !== e.st ||
          bus.depth !== e.d ||
          bus.stack_ovf !== e.ovf ||
          bus.stack_unf !== e.unf) begin
        errors++;
        $display(
          "FAIL %s: got v=%b b=%b st=%b d=%0d o=%b u=%b exp v=%b b=%b st=%b d=%0d o=%b u=%b",
          e.name, bus.ex_valid, ab, bus.stall_req,
          bus.depth, bus.stack_ovf, bus.stack_unf,
          e.v, e.b, e.st, e.d, e.ovf, e.unf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.opcode   = '0;
    bus.hazard   = 1'b0;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;

    step("rst0", 1, 0, 0,   0, 0, 0, 0, B0, 0, 0, 0, 0);
    step("rst1", 1, 1, LD,  0, 0, 0, 0, B0, 0, 0, 0, 0);
    step("ld",   0, 1, LD,  0, 0, 0, 1, B_LD, 0, 0, 0, 0);
    step("hz",   0, 1, ST,  1, 0, 0, 0, B0, 0, 0, 0, 0);
    step("st",   0, 1, ST,  0, 0, 0, 1, B_ST, 0, 0, 0, 0);
    step("art",  0, 1, ART, 0, 0, 0, 1, B_ART, 0, 0, 0, 0);
    step("log",  0, 1, LOG, 0, 0, 0, 1, B_ART, 0, 0, 0, 0);
    step("jmp",  0, 1, JMP, 0, 0, 0, 1, B_JMP, 0, 0, 0, 0);
    step("bqe",  0, 1, BQE, 0, 0, 0, 1, B_BQE, 0, 0, 0, 0);
    step("bne",  0, 1, BNE, 0, 0, 0, 1, B_BNE, 0, 0, 0, 0);
    step("cry",  0, 1, CRY, 0, 0, 0, 1, B_CRY, 0, 0, 0, 0);
    step("und",  0, 1, UND, 0, 0, 0, 1, B0, 0, 0, 0, 0);
    step("inv",  0, 0, LD,  0, 0, 0, 0, B0, 0, 0, 0, 0);
    step("hzcl", 0, 1, CALL, 1, 0, 0, 0, B0, 0, 0, 0, 0);

    step("call1", 0, 1, CALL, 0, 0, 0, 1, B_CAL, 0, 1, 0, 0);
    step("call2", 0, 1, CALL, 0, 0, 0, 1, B_CAL, 0, 2, 0, 0);
    step("call3", 0, 1, CALL, 0, 0, 0, 0, B0, 0, 2, 1, 0);
    for (int i = 0; i < 10; i++)
      step("ovfhold", 0, 0, 0, 0, 0, 0, 0, B0, 0, 2, 1, 0);

    step("ret",   0, 1, RET, 0, 0, 0, 1, B_RET, 1, 1, 1, 0);
    step("wait1", 0, 1, LD,  0, 0, 0, 0, B0, 1, 1, 1, 0);
    step("wait2", 0, 1, LD,  0, 0, 0, 0, B0, 0, 1, 1, 0);
    step("resume",0, 1, LD,  0, 0, 0, 1, B_LD, 0, 1, 1, 0);

    step("ret2",  0, 1, RET, 0, 0, 0, 1, B_RET, 1, 0, 1, 0);
    step("w2a",   0, 0, 0,   0, 0, 0, 0, B0, 1, 0, 1, 0);
    step("w2b",   0, 0, 0,   0, 0, 0, 0, B0, 0, 0, 1, 0);

    step("rstovf", 1, 0, 0,  0, 0, 0, 0, B0, 0, 0, 0, 0);
    step("unf",    0, 1, RET, 0, 0, 0, 0, B0, 0, 0, 0, 1);
    step("unfidl", 0, 1, LD,  0, 0, 0, 1, B_LD, 0, 0, 0, 1);

    step("imm",   0, 1, IMM,  0, 0, 0, 1, B_IMM, 0, 0, 0, 1);
    step("hold1", 0, 1, CALL, 0, 1, 0, 1, B_IMM, 0, 0, 0, 1);
    step("hold2", 0, 1, CALL, 0, 1, 0, 1, B_IMM, 0, 0, 0, 1);
    step("hold3", 0, 1, CALL, 0, 1, 0, 1, B_IMM, 0, 0, 0, 1);
    step("flush", 0, 1, CALL, 0, 0, 1, 0, B0, 0, 0, 0, 1);
    step("flhd",  0, 1, LD,   0, 0, 0, 1, B_LD, 0, 0, 0, 1);
    step("flhd2", 0, 1, LD,   0, 1, 1, 0, B0, 0, 0, 0, 1);

    step("c1",    0, 1, CALL, 0, 0, 0, 1, B_CAL, 0, 1, 0, 1);
    step("r1",    0, 1, RET,  0, 0, 0, 1, B_RET, 1, 0, 0, 1);
    step("wfl",   0, 1, LD,   0, 0, 1, 0, B0, 0, 0, 0, 1);
    step("afl",   0, 1, LD,   0, 0, 0, 1, B_LD, 0, 0, 0, 1);

    step("c2",    0, 1, CALL, 0, 0, 0, 1, B_CAL, 0, 1, 0, 1);
    step("c3",    0, 1, CALL, 0, 0, 0, 1, B_CAL, 0, 2, 0, 1);
    step("r3",    0, 1, RET,  0, 0, 0, 1, B_RET, 1, 1, 0, 1);
    step("hwait", 0, 1, LD,   0, 1, 0, 1, B_RET, 1, 1, 0, 1);
    step("rstw",  1, 1, LD,   0, 0, 0, 0, B0, 0, 0, 0, 0);
    step("post",  0, 1, ST,   0, 0, 0, 1, B_ST, 0, 0, 0, 0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
